// File: rtl/modexp_rl_if.sv
// ---------------------------------------------------------------------------
// modexp_rl_if
//   Start/done handshake bundle for the right-to-left modular exponentiation
//   engine.
//
//   Signals:
//     start   request pulse toward the engine (sampled only in IDLE)
//     base    base operand, captured on an accepted start
//     exp     exponent, captured on an accepted start
//     modn    modulus, captured on an accepted start
//     busy    engine is in LOAD or STEP
//     done    one-cycle completion pulse
//     err     modulus was zero; held until the next accepted start
//     result  base^exp mod modn; held until the next completion
//
//   Modports:
//     master  requester side (drives operands and start)
//     slave   engine side (drives status and result)
// ---------------------------------------------------------------------------
interface modexp_rl_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] modn;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, base, exp, modn,
        input  busy, done, err, result
    );

    modport slave (
        input  start, base, exp, modn,
        output busy, done, err, result
    );
endinterface

// File: rtl/modexp_rl.sv
// ---------------------------------------------------------------------------
// modexp_rl
//   Sequential right-to-left (LSB-first) binary modular exponentiation:
//   result = base^exp mod modn. The exponent is consumed from bit 0 upward,
//   one bit per STEP cycle, under a small control FSM
//   (IDLE -> LOAD -> STEP* -> DONE -> IDLE).
//
//   Ports:
//     clk   system clock, all state changes on posedge
//     rst   synchronous active-high reset; aborts any running operation
//     bus   modexp_rl_if.slave
//             start/base/exp/modn  request and operands (captured in IDLE)
//             busy                 high in LOAD and STEP
//             done                 one-cycle pulse in DONE
//             err                  modn == 0 on the last accepted request
//             result               final value, stable until next completion
//
//   Latency with start sampled at edge t and L = bit length of exp:
//     done in cycle t+L+3, busy over t+1 .. t+L+2, error path done at t+2.
// ---------------------------------------------------------------------------
module modexp_rl #(
    parameter int WIDTH = 64
) (
    input logic        clk,
    input logic        rst,
    modexp_rl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // A zero modulus never reaches the reduction in a legal flow (LOAD
    // diverts to the error path), but the combinational reducers still see
    // it while idle; substituting 1 keeps the divider well defined.
    function automatic logic [WIDTH-1:0] safe_mod(input logic [WIDTH-1:0] m);
        return (m == '0) ? WIDTH'(1) : m;
    endfunction

    // Full 2*WIDTH-bit product reduced by the zero-extended modulus.
    function automatic logic [WIDTH-1:0] mulmod(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] m
    );
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] rem;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, x};
        rem  = prod % {{WIDTH{1'b0}}, safe_mod(m)};
        return rem[WIDTH-1:0];
    endfunction

    // Single-width reduction used to bring the captured base into range.
    function automatic logic [WIDTH-1:0] modreduce(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] m
    );
        return a % safe_mod(m);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state;
    logic [WIDTH-1:0] b;         // running base power: base^(2^i) mod n
    logic [WIDTH-1:0] r;         // running result accumulator
    logic [WIDTH-1:0] e;         // remaining exponent bits, shifted right
    logic [WIDTH-1:0] n;         // captured modulus
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    logic [WIDTH-1:0] rb_next;
    logic [WIDTH-1:0] bb_next;
    logic [WIDTH-1:0] b_red;

    // Both products come from the old b so the multiply and the square of
    // one iteration are independent and land in the same edge.
    assign rb_next = mulmod(r, b, n);
    assign bb_next = mulmod(b, b, n);
    assign b_red   = modreduce(b, n);

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            b        <= '0;
            r        <= '0;
            e        <= '0;
            n        <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        b     <= bus.base;
                        e     <= bus.exp;
                        n     <= bus.modn;
                        err_q <= 1'b0;
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (n == '0) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        state    <= ST_DONE;
                    end else begin
                        b     <= b_red;
                        // x^0 mod 1 is 0, so seed the accumulator accordingly.
                        r     <= (n == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state <= ST_STEP;
                    end
                end

                ST_STEP: begin
                    if (e == '0) begin
                        result_q <= r;
                        state    <= ST_DONE;
                    end else begin
                        if (e[0]) begin
                            r <= rb_next;
                        end
                        b <= bb_next;
                        e <= e >> 1;
                    end
                end

                ST_DONE: begin
                    // A start seen here is dropped; only IDLE accepts.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is decoded from the state register only, so no input reaches
    // an output combinationally.
    assign bus.busy   = (state == ST_LOAD) || (state == ST_STEP);
    assign bus.done   = (state == ST_DONE);
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_modexp_rl.sv
module tb_modexp_rl;

    localparam int W = 64;

    logic clk;
    logic rst;

    modexp_rl_if #(.WIDTH(W)) bus ();

    modexp_rl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nmis;

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] ex;
        logic [W-1:0] modn;
        logic [W-1:0] res;
        logic         err;
        int           lat;
        string        name;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // One complete operation; inputs driven at negedge, outputs sampled at
    // negedge. Cycle k=1 is the cycle right after the accepting edge.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] want,
                          input logic werr, input int lat, input string nm);
        int got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = b;
        bus.exp   = e;
        bus.modn  = m;
        @(negedge clk);
        bus.start = 1'b0;
        got = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) chk({nm, "_err_clear"}, W'(bus.err), W'(0));
            chk({nm, "_busy"}, W'(bus.busy), W'(k < lat));
            if (bus.done) begin
                got = k;
                break;
            end
        end
        chk({nm, "_latency"}, W'(got), W'(lat));
        chk({nm, "_result"}, bus.result, want);
        chk({nm, "_err"}, W'(bus.err), W'(werr));
        @(negedge clk);
        chk({nm, "_done_pulse"}, W'(bus.done), W'(0));
        chk({nm, "_idle_busy"}, W'(bus.busy), W'(0));
        chk({nm, "_hold"}, bus.result, want);
    endtask

    initial begin
        int first_done;
        int ndone;
        nvec = 0;
        nmis = 0;

        tbl[0]  = '{64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 7, "basic"};
        tbl[1]  = '{64'd3, 64'd0, 64'd7, 64'd1, 1'b0, 3, "exp0"};
        tbl[2]  = '{64'd3, 64'd0, 64'd1, 64'd0, 1'b0, 3, "exp0_mod1"};
        tbl[3]  = '{64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h4000_0000_0000_0000, 1'b0, 5, "wide"};
        tbl[4]  = '{64'd5, 64'd9, 64'd0, 64'd0, 1'b1, 2, "modzero"};
        tbl[5]  = '{64'd5, 64'd3, 64'd13, 64'd8, 1'b0, 5, "after_err"};
        tbl[6]  = '{64'd2, 64'd10, 64'd1000, 64'd24, 1'b0, 7, "pow2"};
        tbl[7]  = '{64'd100, 64'd1, 64'd7, 64'd2, 1'b0, 4, "base_gt_mod"};
        tbl[8]  = '{64'd1, 64'h8000_0000_0000_0000, 64'd13, 64'd1, 1'b0, 67, "maxlat"};
        tbl[9]  = '{64'd0, 64'd5, 64'd11, 64'd0, 1'b0, 6, "base0"};
        tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 1'b0, 4, "base_eq_mod"};
        tbl[11] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd1, 1'b0, 5, "minus1_sq"};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.base  = '0;
        bus.exp   = '0;
        bus.modn  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_err", W'(bus.err), W'(0));
        chk("rst_result", bus.result, W'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].base, tbl[i].ex, tbl[i].modn, tbl[i].res,
                   tbl[i].err, tbl[i].lat, tbl[i].name);
        end

        // start held high: back-to-back, a start in DONE is not taken.
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = 64'd5;
        bus.exp   = 64'd3;
        bus.modn  = 64'd13;
        first_done = 0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = k;
                else chk("hold_second_done", W'(k), W'(11));
            end
            if (k == 6) chk("hold_idle_gap", W'(bus.busy), W'(0));
            if (k == 7) chk("hold_reaccept", W'(bus.busy), W'(1));
            if (k == 11) bus.start = 1'b0;
        end
        chk("hold_first_done", W'(first_done), W'(5));
        chk("hold_ndone", W'(ndone), W'(2));
        chk("hold_result", bus.result, W'(8));

        // start pulse in STEP plus operand changes while busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = 64'd4;
        bus.exp   = 64'd13;
        bus.modn  = 64'd497;
        first_done = 0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 2) begin
                bus.base = 64'd9;
                bus.exp  = 64'd7;
                bus.modn = 64'd0;
            end
            if (k == 3) bus.start = 1'b1;
            if (k == 5) chk("ign_result_kept", bus.result, W'(8));
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        chk("ign_done_at", W'(first_done), W'(7));
        chk("ign_ndone", W'(ndone), W'(1));
        chk("ign_result", bus.result, W'(445));
        chk("ign_err", W'(bus.err), W'(0));

        // reset in the middle of STEP.
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = 64'd3;
        bus.exp   = 64'hFFFF;
        bus.modn  = 64'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", W'(bus.busy), W'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", W'(bus.busy), W'(0));
        chk("mid_rst_done", W'(bus.done), W'(0));
        chk("mid_rst_result", bus.result, W'(0));
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mid_no_done", W'(ndone), W'(0));
        run_op(64'd5, 64'd3, 64'd13, 64'd8, 1'b0, 5, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/modexp_rl.md
Name: modexp_rl

Overview:
- Sequential right-to-left (LSB-first) binary modular exponentiation engine: result = base^exp mod modn.
- It is the counterpart to the team's left-to-right, MSB-first square-and-multiply step cell. This block walks the exponent from bit 0 upward, iterating internally under its own control FSM.
- Start/done handshake. Sits beside the step datapath in the RSA path and serves as the self-contained exponentiation unit for the encrypt/decrypt top level.

Parameters:
- WIDTH, 64, operand/result width in bits. All products are formed at 2*WIDTH before reduction.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- base  input  WIDTH  base operand; captured when start is accepted.
- exp  input  WIDTH  exponent; captured when start is accepted.
- modn  input  WIDTH  modulus; captured when start is accepted.
- busy  output  1  high in LOAD and STEP.
- done  output  1  one-cycle pulse in DONE.
- err  output  1  set when modn == 0; held until next accepted start or rst.
- result  output  WIDTH  final value; held stable from DONE until the next accepted start.

Behaviour:
- Reset, checked first every edge:
  - State = IDLE.
  - busy = 0, done = 0, err = 0, result = 0.
  - Internal b, r, e, n registers cleared.
  - rst mid-operation aborts immediately: no done pulse, no partial result.
- IDLE:
  - start = 1 → capture base/exp/modn into b/e/n, clear err, go LOAD.
  - Otherwise stay in IDLE.
  - start while busy or in DONE is ignored, not queued.
- LOAD (one cycle):
  - If n == 0: err <= 1, result <= 0, go DONE.
  - Else: b <= b mod n; r <= (n == 1) ? 0 : 1; go STEP.
- STEP (one cycle per iteration):
  - If e == 0: result <= r, go DONE.
  - Else:
    - If e[0] = 1: r <= (r*b) mod n.
    - Always: b <= (b*b) mod n.
    - e <= e >> 1.
    - r and b update in parallel from the old b.
- DONE (one cycle): done = 1, then IDLE. start in this cycle is ignored.
- Arithmetic:
  - Both products are full 2*WIDTH-bit unsigned; no truncation before mod.
  - Reduction is combinational modulo of the 2*WIDTH product by the zero-extended n.
  - All values are unsigned.
- Latency, with start sampled at edge t and L = index of highest set bit of exp + 1 (L = 0 for exp = 0):
  - done is high in cycle t+L+3.
  - busy is high for cycles t+1 .. t+L+2.
  - Error path (modn == 0): done is high in cycle t+2.
  - Maximum latency is WIDTH+3 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Input changes after capture have no effect on the running operation.
- result and err keep their values after DONE until the next accepted start; err clears on that start, result is overwritten at completion.

Test Plan:
- Basic: base=4, exp=13, modn=497, start at t → done=1 only at t+7, result=445, err=0; busy high t+1..t+6.
- Zero exponent: base=3, exp=0, modn=7 → done at t+3, result=1. Repeat with modn=1 → result=0.
- Wide product: base=2^63, exp=2, modn=2^64-1 → result=2^62. Truncated-product implementations fail this case.
- Error: modn=0, any base/exp → done at t+2, err=1, result=0. A following legal start (5^3 mod 13) → err=0 at t+1, result=8.
- Handshake:
  - start held high continuously → back-to-back operations, each accepted only from IDLE.
  - start pulse during STEP → ignored, result unchanged.
  - Operands changed while busy → no effect on the result.
- Reset mid-op: rst asserted during STEP of exp=0xFFFF → next cycle IDLE, busy=0, done=0, result=0; no done pulse afterwards. A fresh start then completes correctly.
